// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: counter width and wrap-around pointer increment.
package fifo_pkg;

  function automatic int unsigned fifo_cnt_w(input int unsigned depth);
    return 32'($clog2(depth + 32'd1));
  endfunction

  // Wraps explicitly at depth-1 so non-power-of-2 depths work.
  function automatic int unsigned fifo_ptr_inc(input int unsigned ptr,
                                               input int unsigned depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_status_if.sv
// Request and status bundle between a FIFO producer/consumer and fifo_status.
interface fifo_status_if
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned MAX_DEPTH = 16
);
  localparam int unsigned CW = fifo_cnt_w(MAX_DEPTH);

  logic                 write_to_fifo;
  logic                 read_from_fifo;
  logic [DATA_SIZE-1:0] write_data_in;
  logic [DATA_SIZE-1:0] read_data_out;
  logic                 empty;
  logic                 full;
  logic                 almost_empty;
  logic                 almost_full;
  logic [CW-1:0]        count;
  logic                 overflow;
  logic                 underflow;

  modport master (
    output write_to_fifo, read_from_fifo, write_data_in,
    input  read_data_out, empty, full, almost_empty, almost_full, count,
           overflow, underflow
  );

  modport slave (
    input  write_to_fifo, read_from_fifo, write_data_in,
    output read_data_out, empty, full, almost_empty, almost_full, count,
           overflow, underflow
  );
endinterface

// File: rtl/fifo_ram.sv
// FIFO storage: synchronous write port, asynchronous read port, never cleared.
module fifo_ram #(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned MAX_DEPTH = 16,
  parameter int unsigned AW        = $clog2(MAX_DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [DATA_SIZE-1:0] wdata,
  input  logic [AW-1:0]        raddr,
  output logic [DATA_SIZE-1:0] rdata
);
  logic [DATA_SIZE-1:0] mem [MAX_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_status.sv
// Synchronous FIFO controller: pointers, occupancy, registered flags and
// one-cycle overflow/underflow pulses around a fifo_ram.
module fifo_status
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned MAX_DEPTH = 16,
  parameter int unsigned AF_THRESH = 12,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic          clk,
  input  logic          reset,
  fifo_status_if.slave  bus
);
  localparam int unsigned CW = fifo_cnt_w(MAX_DEPTH);
  localparam int unsigned PW = $clog2(MAX_DEPTH);

  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DEPTH);
  localparam logic [CW-1:0] AF_T    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_T    = CW'(AE_THRESH);
  localparam logic          AF_RST  = (AF_THRESH == 0);

  logic          rd_ok, wr_ok;
  logic [PW-1:0] wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
  logic [CW-1:0] count_d, count_q;
  logic          empty_d, empty_q, full_d, full_q;
  logic          almost_empty_d, almost_empty_q, almost_full_d, almost_full_q;
  logic          overflow_d, overflow_q, underflow_d, underflow_q;

  // Acceptance, pointer advance and flags computed from the next count.
  always_comb begin
    rd_ok          = bus.read_from_fifo & ~empty_q;
    wr_ok          = bus.write_to_fifo & (~full_q | rd_ok);
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    if (wr_ok) wr_ptr_d = PW'(fifo_ptr_inc(32'(wr_ptr_q), MAX_DEPTH));
    if (rd_ok) rd_ptr_d = PW'(fifo_ptr_inc(32'(rd_ptr_q), MAX_DEPTH));
    count_d        = count_q + CW'(wr_ok) - CW'(rd_ok);
    empty_d        = (count_d == '0);
    full_d         = (count_d == CNT_MAX);
    almost_empty_d = (count_d <= AE_T);
    almost_full_d  = (count_d >= AF_T);
    overflow_d     = bus.write_to_fifo & ~wr_ok;
    underflow_d    = bus.read_from_fifo & ~rd_ok;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      empty_q        <= 1'b1;
      full_q         <= 1'b0;
      almost_empty_q <= 1'b1;
      almost_full_q  <= AF_RST;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      empty_q        <= empty_d;
      full_q         <= full_d;
      almost_empty_q <= almost_empty_d;
      almost_full_q  <= almost_full_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  // Write is masked during reset so a flushed request leaves no trace.
  fifo_ram #(
    .DATA_SIZE (DATA_SIZE),
    .MAX_DEPTH (MAX_DEPTH),
    .AW        (PW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_ok & ~reset),
    .waddr (wr_ptr_q),
    .wdata (bus.write_data_in),
    .raddr (rd_ptr_q),
    .rdata (bus.read_data_out)
  );

  assign bus.count        = count_q;
  assign bus.empty        = empty_q;
  assign bus.full         = full_q;
  assign bus.almost_empty = almost_empty_q;
  assign bus.almost_full  = almost_full_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_status.sv
// Bench for fifo_status: directed boundary scenarios plus random traffic,
// all checked against a queue-based reference model.
module tb_fifo_status;
  localparam int unsigned DEPTH = 6;
  localparam int unsigned AF    = 5;
  localparam int unsigned AE    = 1;

  logic clk = 1'b0;
  logic reset;

  fifo_status_if #(.DATA_SIZE(8), .MAX_DEPTH(DEPTH)) bus ();

  fifo_status #(
    .DATA_SIZE (8),
    .MAX_DEPTH (DEPTH),
    .AF_THRESH (AF),
    .AE_THRESH (AE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mq [$];
  bit         m_ovf, m_udf;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int n;
    n = mq.size();
    check("count",     32'(bus.count),        32'(n));
    check("empty",     32'(bus.empty),        32'(n == 0));
    check("full",      32'(bus.full),         32'(n == int'(DEPTH)));
    check("almost_e",  32'(bus.almost_empty), 32'(n <= int'(AE)));
    check("almost_f",  32'(bus.almost_full),  32'(n >= int'(AF)));
    check("overflow",  32'(bus.overflow),     32'(m_ovf));
    check("underflow", 32'(bus.underflow),    32'(m_udf));
    if (n > 0) check("head", 32'(bus.read_data_out), 32'(mq[0]));
  endtask

  // One clock: drive, apply the FIFO rules to the model, then compare.
  task automatic step(input logic rst, input logic wr, input logic rd, input logic [7:0] d);
    bit rok, wok;
    reset              = rst;
    bus.write_to_fifo  = wr;
    bus.read_from_fifo = rd;
    bus.write_data_in  = d;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      rok = rd && (mq.size() > 0);
      wok = wr && ((mq.size() < int'(DEPTH)) || rok);
      if (rok) void'(mq.pop_front());
      if (wok) mq.push_back(d);
      m_ovf = wr && !wok;
      m_udf = rd && !rok;
    end
    #1;
    check_outputs();
  endtask

  initial begin
    bit w, r;
    int wi, ri;
    logic [7:0] lit;
    reset              = 1'b1;
    bus.write_to_fifo  = 1'b0;
    bus.read_from_fifo = 1'b0;
    bus.write_data_in  = '0;
    @(negedge clk);

    // Reset held two cycles
    step(1, 0, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_af",    32'(bus.almost_full), 32'd0);

    // Fill to full, then one rejected write
    for (int i = 1; i <= 6; i++) begin
      step(0, 1, 0, 8'(8'h11 * i));
      if (i == 2) check("fill_ae_off", 32'(bus.almost_empty), 32'd0);
      if (i == 5) check("fill_af_on",  32'(bus.almost_full),  32'd1);
    end
    check("fill_full", 32'(bus.full), 32'd1);
    step(0, 1, 0, 8'h77);
    check("ovf_pulse", 32'(bus.overflow), 32'd1);
    step(0, 0, 0, 8'h00);
    check("ovf_clear", 32'(bus.overflow), 32'd0);

    // Drain in order, then one rejected read
    for (int i = 1; i <= 6; i++) begin
      lit = 8'(8'h11 * i);
      check("drain_head", 32'(bus.read_data_out), 32'(lit));
      step(0, 0, 1, 8'h00);
    end
    check("drain_empty", 32'(bus.empty), 32'd1);
    step(0, 0, 1, 8'h00);
    check("udf_pulse", 32'(bus.underflow), 32'd1);

    // Interleaved wrap traffic, occupancy kept within 1..5
    wi = 0;
    ri = 0;
    step(0, 1, 0, 8'(wi));
    wi++;
    for (int it = 0; it < 300 && ri < 20; it++) begin
      w = (wi < 20) && (mq.size() < 5) && ($urandom_range(0, 1) == 1 || mq.size() <= 1);
      r = (mq.size() > 1 || (mq.size() == 1 && (w || wi == 20))) &&
          ($urandom_range(0, 1) == 1 || mq.size() == 5 || wi == 20);
      if (r) begin
        check("wrap_order", 32'(bus.read_data_out), 32'(ri));
        ri++;
      end
      step(0, w, r, 8'(wi));
      if (w) wi++;
    end
    check("wrap_done", 32'(ri), 32'd20);

    // Full with simultaneous read and write
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 8'(8'h10 + i));
    step(0, 1, 1, 8'hA5);
    check("rw_full_cnt",  32'(bus.count), 32'd6);
    check("rw_full_head", 32'(bus.read_data_out), 32'h11);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) check("rw_full_last", 32'(bus.read_data_out), 32'hA5);
      step(0, 0, 1, 8'h00);
    end

    // Empty with simultaneous read and write
    step(0, 1, 1, 8'h5A);
    check("rw_empty_cnt",  32'(bus.count), 32'd1);
    check("rw_empty_udf",  32'(bus.underflow), 32'd1);
    check("rw_empty_head", 32'(bus.read_data_out), 32'h5A);

    // Reset overrides pending requests
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 8'(8'h30 + i));
    step(1, 1, 1, 8'hEE);
    check("rst_ovr_cnt",   32'(bus.count), 32'd0);
    check("rst_ovr_empty", 32'(bus.empty), 32'd1);
    step(0, 1, 0, 8'h42);
    check("rst_ovr_head",  32'(bus.read_data_out), 32'h42);
    check("rst_ovr_cnt1",  32'(bus.count), 32'd1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 55,
           $urandom_range(0, 99) < 50,
           8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
